// File: rtl/conv1d_ctrl_pkg.sv
// Shared encodings for the Conv1D job sequencer: phase, step and top-level state.
// Imported by conv1d_job_sequencer and conv1d_phase_watchdog.
package conv1d_ctrl_pkg;

   typedef enum logic [2:0] {
      PH_WEIGHT = 3'd0,
      PH_OLOAD  = 3'd1,
      PH_ILOAD  = 3'd2,
      PH_COMP   = 3'd3,
      PH_WBACK  = 3'd4
   } phase_e;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_GO   = 2'd1,
      ST_ARM  = 2'd2,
      ST_WAIT = 2'd3
   } step_e;

   typedef enum logic [1:0] {
      TOP_IDLE  = 2'd0,
      TOP_RUN   = 2'd1,
      TOP_DONE  = 2'd2,
      TOP_FAULT = 2'd3
   } top_e;

   // WBACK wraps to OLOAD; the caller decides whether the job is finished instead.
   function automatic phase_e phase_after(input phase_e p);
      phase_e n;
      case (p)
         PH_WEIGHT: n = PH_OLOAD;
         PH_OLOAD:  n = PH_ILOAD;
         PH_ILOAD:  n = PH_COMP;
         PH_COMP:   n = PH_WBACK;
         default:   n = PH_OLOAD;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/conv1d_phase_watchdog.sv
// Busy-cycle watchdog for one WAIT step: clears on WAIT entry, counts busy-high
// cycles, flags expiry on the cycle that would make the count reach the limit.
module conv1d_phase_watchdog
   import conv1d_ctrl_pkg::*;
#(
   parameter int Watchdog_Limit   = 64,
   parameter int Watchdog_in_bits = 7
) (
   input  logic clk,
   input  logic Reset_n,
   input  logic clr,
   input  logic cnt_en,
   output logic expired
);

   localparam logic [Watchdog_in_bits-1:0] CNT_LAST = Watchdog_in_bits'(Watchdog_Limit - 1);
   localparam logic [Watchdog_in_bits-1:0] CNT_ONE  = Watchdog_in_bits'(1);

   logic [Watchdog_in_bits-1:0] cnt_q;
   logic [Watchdog_in_bits-1:0] cnt_d;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_en) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   assign expired = cnt_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/conv1d_job_sequencer.sv
// Conv1D phase sequencer: one Start/Done job drives WEIGHT once, then OLOAD/ILOAD/COMP/WBACK
// per tile. Optional busy watchdog with FAULT state under CONV_PHASE_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | waiting for Start, all outputs low
// RUN/RST    | phase index/step reset pulse
// RUN/GO     | phase command pulse
// RUN/ARM    | busy ignored while MEMController raises it
// RUN/WAIT   | hold while the phase busy level is high
// DONE       | one-cycle Done pulse
// FAULT      | watchdog expired, held until Abort or reset
module conv1d_job_sequencer
   import conv1d_ctrl_pkg::*;
#(
   parameter int Tile_Count_in_bits = 4,
   parameter int Watchdog_Limit     = 64,
   parameter int Watchdog_in_bits   = 7
) (
   input  logic                          clk,
   input  logic                          Reset_n,
   input  logic                          Start,
   input  logic                          Abort,
   input  logic [Tile_Count_in_bits-1:0] Num_Tiles,
   input  logic                          Weight_Loading_From_File,
   input  logic                          Output_Loading_From_File,
   input  logic                          Input_Loading_From_File,
   input  logic                          Computing,
   input  logic                          Output_Writing_To_File,
   output logic                          Weight_Mem_Index_Reset,
   output logic                          Output_Mem_Index_Reset,
   output logic                          Input_Mem_Index_Reset,
   output logic                          Comp_Reset,
   output logic                          Weight_Loading_Signal,
   output logic                          Output_Loading_Signal,
   output logic                          Input_Loading_Signal,
   output logic                          Computing_Signal,
   output logic                          Output_Writing_Signal,
   output logic                          Busy,
   output logic                          Done,
   output logic                          Fault,
   output logic [Tile_Count_in_bits-1:0] Tile_Idx
);

   localparam logic [Tile_Count_in_bits-1:0] TILE_ONE = Tile_Count_in_bits'(1);

   top_e                          top_q,    top_d;
   phase_e                        phase_q,  phase_d;
   step_e                         step_q,   step_d;
   logic [Tile_Count_in_bits-1:0] tile_q,   tile_d;
   logic [Tile_Count_in_bits-1:0] ntiles_q, ntiles_d;
   logic                          sel_busy;
   logic                          last_tile;

   always_comb begin
      sel_busy = 1'b0;
      case (phase_q)
         PH_WEIGHT: sel_busy = Weight_Loading_From_File;
         PH_OLOAD:  sel_busy = Output_Loading_From_File;
         PH_ILOAD:  sel_busy = Input_Loading_From_File;
         PH_COMP:   sel_busy = Computing;
         PH_WBACK:  sel_busy = Output_Writing_To_File;
         default:   sel_busy = 1'b0;
      endcase
   end

   assign last_tile = (tile_q == (ntiles_q - TILE_ONE));

`ifdef CONV_PHASE_WATCHDOG_EN
   logic wd_clr;
   logic wd_en;
   logic wd_expired;

   assign wd_clr = (top_q == TOP_RUN) && (step_q == ST_ARM);
   assign wd_en  = (top_q == TOP_RUN) && (step_q == ST_WAIT) && sel_busy;

   conv1d_phase_watchdog #(
      .Watchdog_Limit   (Watchdog_Limit),
      .Watchdog_in_bits (Watchdog_in_bits)
   ) u_watchdog (
      .clk     (clk),
      .Reset_n (Reset_n),
      .clr     (wd_clr),
      .cnt_en  (wd_en),
      .expired (wd_expired)
   );
`else
   logic unused_wd_cfg;
   assign unused_wd_cfg = (Watchdog_Limit > 0) && (Watchdog_in_bits > 0);
`endif

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         top_q    <= TOP_IDLE;
         phase_q  <= PH_WEIGHT;
         step_q   <= ST_RST;
         tile_q   <= '0;
         ntiles_q <= '0;
      end else begin
         top_q    <= top_d;
         phase_q  <= phase_d;
         step_q   <= step_d;
         tile_q   <= tile_d;
         ntiles_q <= ntiles_d;
      end
   end

   always_comb begin
      top_d    = top_q;
      phase_d  = phase_q;
      step_d   = step_q;
      tile_d   = tile_q;
      ntiles_d = ntiles_q;
      if (Abort) begin
         top_d   = TOP_IDLE;
         phase_d = PH_WEIGHT;
         step_d  = ST_RST;
         tile_d  = '0;
      end else begin
         case (top_q)
            TOP_IDLE: begin
               if (Start) begin
                  ntiles_d = Num_Tiles;
                  tile_d   = '0;
                  phase_d  = PH_WEIGHT;
                  step_d   = ST_RST;
                  top_d    = (Num_Tiles == '0) ? TOP_DONE : TOP_RUN;
               end
            end
            TOP_RUN: begin
               case (step_q)
                  ST_RST: step_d = ST_GO;
                  ST_GO:  step_d = ST_ARM;
                  ST_ARM: step_d = ST_WAIT;
                  default: begin
`ifdef CONV_PHASE_WATCHDOG_EN
                     if (wd_expired) begin
                        top_d = TOP_FAULT;
                     end else
`endif
                     if (!sel_busy) begin
                        step_d = ST_RST;
                        if (phase_q != PH_WBACK) begin
                           phase_d = phase_after(phase_q);
                        end else if (last_tile) begin
                           top_d = TOP_DONE;
                        end else begin
                           tile_d  = tile_q + TILE_ONE;
                           phase_d = phase_after(phase_q);
                        end
                     end
                  end
               endcase
            end
            TOP_DONE: begin
               top_d  = TOP_IDLE;
               tile_d = '0;
            end
`ifdef CONV_PHASE_WATCHDOG_EN
            TOP_FAULT: top_d = TOP_FAULT;
`endif
            default: top_d = TOP_IDLE;
         endcase
      end
   end

   always_comb begin
      Weight_Mem_Index_Reset = 1'b0;
      Output_Mem_Index_Reset = 1'b0;
      Input_Mem_Index_Reset  = 1'b0;
      Comp_Reset             = 1'b0;
      Weight_Loading_Signal  = 1'b0;
      Output_Loading_Signal  = 1'b0;
      Input_Loading_Signal   = 1'b0;
      Computing_Signal       = 1'b0;
      Output_Writing_Signal  = 1'b0;
      Busy                   = 1'b0;
      Done                   = 1'b0;
`ifdef CONV_PHASE_WATCHDOG_EN
      Fault                  = 1'b0;
`endif
      case (top_q)
         TOP_RUN: begin
            Busy = 1'b1;
            if (step_q == ST_RST) begin
               case (phase_q)
                  PH_WEIGHT:          Weight_Mem_Index_Reset = 1'b1;
                  PH_OLOAD, PH_WBACK: Output_Mem_Index_Reset = 1'b1;
                  PH_ILOAD:           Input_Mem_Index_Reset  = 1'b1;
                  PH_COMP:            Comp_Reset             = 1'b1;
                  default: ;
               endcase
            end else if (step_q == ST_GO) begin
               case (phase_q)
                  PH_WEIGHT: Weight_Loading_Signal = 1'b1;
                  PH_OLOAD:  Output_Loading_Signal = 1'b1;
                  PH_ILOAD:  Input_Loading_Signal  = 1'b1;
                  PH_COMP:   Computing_Signal      = 1'b1;
                  PH_WBACK:  Output_Writing_Signal = 1'b1;
                  default: ;
               endcase
            end
         end
         TOP_DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
`ifdef CONV_PHASE_WATCHDOG_EN
         TOP_FAULT: begin
            Busy  = 1'b1;
            Fault = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifndef CONV_PHASE_WATCHDOG_EN
   assign Fault = 1'b0;
`endif

   assign Tile_Idx = tile_q;

endmodule

// File: tb/tb_conv1d_job_sequencer.sv
// Bench for conv1d_job_sequencer: a job-level model expands each job into the expected
// per-cycle output trace and the busy-level schedule that drives the MEMController inputs.
module tb_conv1d_job_sequencer;

   localparam int TW       = 4;
   localparam int WD_LIMIT = 64;

   logic          clk;
   logic          Reset_n;
   logic          Start;
   logic          Abort;
   logic [TW-1:0] Num_Tiles;
   logic          Weight_Loading_From_File;
   logic          Output_Loading_From_File;
   logic          Input_Loading_From_File;
   logic          Computing;
   logic          Output_Writing_To_File;
   logic          Weight_Mem_Index_Reset;
   logic          Output_Mem_Index_Reset;
   logic          Input_Mem_Index_Reset;
   logic          Comp_Reset;
   logic          Weight_Loading_Signal;
   logic          Output_Loading_Signal;
   logic          Input_Loading_Signal;
   logic          Computing_Signal;
   logic          Output_Writing_Signal;
   logic          Busy;
   logic          Done;
   logic          Fault;
   logic [TW-1:0] Tile_Idx;

   conv1d_job_sequencer #(
      .Tile_Count_in_bits (TW),
      .Watchdog_Limit     (WD_LIMIT),
      .Watchdog_in_bits   (7)
   ) dut (
      .clk                      (clk),
      .Reset_n                  (Reset_n),
      .Start                    (Start),
      .Abort                    (Abort),
      .Num_Tiles                (Num_Tiles),
      .Weight_Loading_From_File (Weight_Loading_From_File),
      .Output_Loading_From_File (Output_Loading_From_File),
      .Input_Loading_From_File  (Input_Loading_From_File),
      .Computing                (Computing),
      .Output_Writing_To_File   (Output_Writing_To_File),
      .Weight_Mem_Index_Reset   (Weight_Mem_Index_Reset),
      .Output_Mem_Index_Reset   (Output_Mem_Index_Reset),
      .Input_Mem_Index_Reset    (Input_Mem_Index_Reset),
      .Comp_Reset               (Comp_Reset),
      .Weight_Loading_Signal    (Weight_Loading_Signal),
      .Output_Loading_Signal    (Output_Loading_Signal),
      .Input_Loading_Signal     (Input_Loading_Signal),
      .Computing_Signal         (Computing_Signal),
      .Output_Writing_Signal    (Output_Writing_Signal),
      .Busy                     (Busy),
      .Done                     (Done),
      .Fault                    (Fault),
      .Tile_Idx                 (Tile_Idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   done_at, w_cnt, c_cnt, job_done_idx, seq;
   bit   noise, faulted;
   logic [15:0] exp_q[$];
   logic [4:0]  drv_q[$];

   // Trace record layout: {rst W,O,I,C | cmd W,O,I,C,WB | Busy, Done, Fault | Tile_Idx}
   function automatic logic [15:0] obs();
      return {Weight_Mem_Index_Reset, Output_Mem_Index_Reset, Input_Mem_Index_Reset, Comp_Reset,
              Weight_Loading_Signal, Output_Loading_Signal, Input_Loading_Signal,
              Computing_Signal, Output_Writing_Signal, Busy, Done, Fault, Tile_Idx};
   endfunction

   function automatic logic [15:0] rec(input logic [3:0] r, input logic [4:0] c,
                                       input logic d, input logic f, input int t);
      return {r, c, 1'b1, d, f, 4'(t)};
   endfunction

   function automatic logic [3:0] rst_of(input int p);
      case (p)
         0:       return 4'b1000;
         1, 4:    return 4'b0100;
         2:       return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   function automatic logic [4:0] rnd5();
      return noise ? 5'($urandom) : 5'b0;
   endfunction

   task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_int(input string tag, input int o, input int e);
      n_cmp++;
      assert (o == e) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   // p: 0 WEIGHT,1 OLOAD,2 ILOAD,3 COMP,4 WBACK; k = busy-high cycles seen in WAIT
   task automatic add_phase(input int p, input int t, input int k);
      logic [4:0] b;
      int         hi;
      if (faulted) return;
      b = 5'b10000 >> p;
      exp_q.push_back(rec(rst_of(p), 5'b0, 1'b0, 1'b0, t)); drv_q.push_back(rnd5());
      exp_q.push_back(rec(4'b0, b, 1'b0, 1'b0, t));         drv_q.push_back(rnd5());
      exp_q.push_back(rec(4'b0, 5'b0, 1'b0, 1'b0, t));      drv_q.push_back(rnd5() | ((k > 0) ? b : 5'b0));
      hi = k;
`ifdef CONV_PHASE_WATCHDOG_EN
      if (k >= WD_LIMIT) hi = WD_LIMIT;
`endif
      for (int j = 0; j < hi; j++) begin
         exp_q.push_back(rec(4'b0, 5'b0, 1'b0, 1'b0, t)); drv_q.push_back(rnd5() | b);
      end
`ifdef CONV_PHASE_WATCHDOG_EN
      if (k >= WD_LIMIT) begin
         faulted = 1'b1;
         for (int j = 0; j < 300; j++) begin
            exp_q.push_back(rec(4'b0, 5'b0, 1'b0, 1'b1, t)); drv_q.push_back(rnd5());
         end
         return;
      end
`endif
      exp_q.push_back(rec(4'b0, 5'b0, 1'b0, 1'b0, t)); drv_q.push_back(rnd5() & ~b);
   endtask

   // Phase sequence number ov_idx (0 = WEIGHT, then 4 per tile) gets busy length ov_k.
   task automatic build_job(input int n, input int kmax, input int ov_idx, input int ov_k);
      exp_q.delete(); drv_q.delete();
      faulted = 1'b0; seq = 0; job_done_idx = -1;
      if (n == 0) begin
         exp_q.push_back(rec(4'b0, 5'b0, 1'b1, 1'b0, 0)); drv_q.push_back(rnd5());
         job_done_idx = 0;
         return;
      end
      for (int s = 0; s < 1 + 4 * n; s++) begin
         add_phase((s == 0) ? 0 : 1 + (s - 1) % 4, (s == 0) ? 0 : (s - 1) / 4,
                   (s == ov_idx) ? ov_k : $urandom_range(0, kmax));
      end
      if (!faulted) begin
         exp_q.push_back(rec(4'b0, 5'b0, 1'b1, 1'b0, n - 1)); drv_q.push_back(rnd5());
         job_done_idx = exp_q.size() - 1;
      end
   endtask

   // Trace index i is the state entered at edge E0+i, where E0 samples Start.
   task automatic run_job(input string name, input int n, input int abort_at, input int reset_at);
      int last;
      bit ended_early;
      last = exp_q.size() - 1;
      done_at = -1; w_cnt = 0; c_cnt = 0; ended_early = 1'b0;
      @(posedge clk); #1;
      Start = 1'b1; Num_Tiles = TW'(n); Abort = 1'b0;
      {Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
       Computing, Output_Writing_To_File} = 5'b0;
      @(posedge clk); #1;
      for (int i = 0; i <= last; i++) begin
         {Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
          Computing, Output_Writing_To_File} = drv_q[i];
         Start     = (i == last || i == abort_at || i == reset_at) ? 1'b0 : 1'($urandom_range(0, 1));
         Num_Tiles = TW'($urandom);
         Abort     = (i == abort_at);
         @(negedge clk);
         check($sformatf("%s_cyc%0d", name, i), obs(), exp_q[i]);
         if (Done) done_at = i;
         w_cnt += int'(Weight_Loading_Signal);
         c_cnt += int'(Computing_Signal);
         if (i == reset_at) begin
            #2 Reset_n = 1'b0;
            #1 check($sformatf("%s_async_reset", name), obs(), 16'h0000);
            @(negedge clk);
            Reset_n = 1'b1;
            ended_early = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (i == abort_at) begin
            Abort = 1'b0;
            {Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
             Computing, Output_Writing_To_File} = 5'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check($sformatf("%s_abort_idle%0d", name, j), obs(), 16'h0000);
               @(posedge clk); #1;
            end
            ended_early = 1'b1;
            break;
         end
      end
      if (!ended_early) begin
         {Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
          Computing, Output_Writing_To_File} = 5'b0;
         @(negedge clk);
         check($sformatf("%s_post_done", name), obs() & 16'hFFF0, 16'h0000);
      end
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Num_Tiles = '0;
      {Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
       Computing, Output_Writing_To_File} = 5'b0;
      #2 check("reset_state", obs(), 16'h0000);
      #21 Reset_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", obs(), 16'h0000);

      noise = 1'b0;
      build_job(1, 0, -1, 0);
      run_job("n1_quiet", 1, -1, -1);
      check_int("n1_done_edge", done_at, 20);

      build_job(3, 0, -1, 0);
      run_job("n3_quiet", 3, -1, -1);
      check_int("n3_done_edge", done_at, 52);
      check_int("n3_weight_cmds", w_cnt, 1);
      check_int("n3_comp_cmds", c_cnt, 3);

      build_job(1, 0, 3, 6);
      run_job("n1_comp6", 1, -1, -1);
      check_int("n1_comp6_done_edge", done_at, 26);
      check_int("n1_comp6_comp_cmds", c_cnt, 1);

      build_job(0, 0, -1, 0);
      run_job("n0", 0, -1, -1);
      check_int("n0_done_edge", done_at, 0);

      noise = 1'b1;
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 4);
         build_job(n, 4, -1, 0);
         run_job($sformatf("rand%0d", r), n, -1, -1);
         check_int($sformatf("rand%0d_done_edge", r), done_at, job_done_idx);
         check_int($sformatf("rand%0d_weight_cmds", r), w_cnt, 1);
         check_int($sformatf("rand%0d_comp_cmds", r), c_cnt, n);
      end

      // ILOAD of tile 1 is phase 6; its WAIT begins at index 27
      build_job(2, 0, 6, 5);
      run_job("abort_iload1", 2, 28, -1);
      check_int("abort_no_done", done_at, -1);

      // COMP of tile 0 is phase 3; its WAIT begins at index 15
      build_job(1, 0, 3, 10);
      run_job("reset_comp", 1, -1, 17);
      check_int("reset_no_done", done_at, -1);

      build_job(1, 0, 3, 250);
      run_job("stuck_comp", 1, 15 + 199, -1);
      check_int("stuck_no_done", done_at, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
